// File: rtl/lsu.sv
// Load/store unit driving a word-wide data memory; sub-word stores run as read-modify-write.
// Define LSU_SUBWORD_EN to support lh/lhu/lb/lbu/sh/sb; otherwise those ops complete as errors.
module lsu #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD,
    output logic        mem_RE,
    output logic        mem_WE,
    output logic [31:0] mem_PC
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACC    = 3'd1;
    localparam logic [2:0] RESP   = 3'd4;
`ifdef LSU_SUBWORD_EN
    localparam logic [2:0] RMW_RD = 3'd2;
    localparam logic [2:0] RMW_WR = 3'd3;
`endif

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    logic [2:0]  state;
    logic [2:0]  op_q;
    logic [31:2] word_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic        err_q;
    logic        misaligned;
    logic        unsupported;
    logic        req_err;
    logic        is_store;
    logic [31:0] load_word;
`ifdef LSU_SUBWORD_EN
    logic [1:0]  lane_q;
    logic [31:0] merged_q;
    logic [31:0] merge_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
`endif

    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:          misaligned = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  misaligned = req_addr[0];
            default:               misaligned = 1'b0;
        endcase
`ifdef LSU_SUBWORD_EN
        unsupported = 1'b0;
`else
        unsupported = (req_op != OP_LW) && (req_op != OP_SW);
`endif
        req_err = misaligned || (req_addr >= ADDR_LIMIT) || unsupported;
    end

    assign is_store = (op_q >= OP_SW);

    // Extract and extend the addressed lane of the word being read in ACC.
    always_comb begin
        load_word = mem_RD;
`ifdef LSU_SUBWORD_EN
        byte_sel = mem_RD[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_RD[31:16] : mem_RD[15:0];
        case (op_q)
            OP_LH:   load_word = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_word = {16'h0000, half_sel};
            OP_LB:   load_word = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_word = {24'h000000, byte_sel};
            default: load_word = mem_RD;
        endcase
`endif
    end

`ifdef LSU_SUBWORD_EN
    always_comb begin
        merge_word = mem_RD;
        if (op_q == OP_SB) begin
            merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_word[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end
`endif

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            word_q   <= 30'd0;
            wdata_q  <= 32'd0;
            pc_q     <= 32'd0;
            err_q    <= 1'b0;
            rdata    <= 32'd0;
`ifdef LSU_SUBWORD_EN
            lane_q   <= 2'd0;
            merged_q <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        word_q  <= req_addr[31:2];
                        wdata_q <= req_wdata;
                        pc_q    <= req_pc;
                        err_q   <= req_err;
`ifdef LSU_SUBWORD_EN
                        lane_q  <= req_addr[1:0];
`endif
                        if (req_err) begin
                            state <= RESP;
`ifdef LSU_SUBWORD_EN
                        end else if ((req_op == OP_SH) || (req_op == OP_SB)) begin
                            state <= RMW_RD;
`endif
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (!is_store) begin
                        rdata <= load_word;
                    end
                    state <= RESP;
                end
`ifdef LSU_SUBWORD_EN
                RMW_RD: begin
                    merged_q <= merge_word;
                    state    <= RMW_WR;
                end
                RMW_WR:  state <= RESP;
`endif
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes and the memory buses are pure decodes of the state so reset kills them at once.
    always_comb begin
        mem_RE = (state == ACC) && !is_store;
        mem_WE = (state == ACC) && is_store;
        mem_WD = 32'd0;
        if ((state == ACC) && is_store) begin
            mem_WD = wdata_q;
        end
`ifdef LSU_SUBWORD_EN
        if (state == RMW_RD) begin
            mem_RE = 1'b1;
        end
        if (state == RMW_WR) begin
            mem_WE = 1'b1;
            mem_WD = merged_q;
        end
`endif
        mem_A = (mem_RE || mem_WE) ? {word_q, 2'b00} : 32'd0;
    end

    assign busy     = (state != IDLE);
    assign done     = (state == RESP);
    assign addr_err = (state == RESP) && err_q;
    assign mem_PC   = pc_q;

endmodule
